// File: rtl/control_unit_mc.sv
// Multicycle RV32I control FSM with memory wait states
// and illegal-opcode trapping.
module control_unit_mc #(
    parameter int MEM_HANDSHAKE   = 1,
    parameter int MEM_LATENCY     = 0,
    parameter int TRAP_ON_ILLEGAL = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       func7_bit5,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       memread,
    output logic       adrsource,
    output logic [2:0] imm_source,
    output logic [1:0] alu_source_a,
    output logic [1:0] alu_source_b,
    output logic [3:0] alu_control,
    output logic [1:0] resultsource,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_MEMADR,
        S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_ALUWB, S_BRANCH, S_JAL,
        S_JALR, S_JALR_PC, S_UPPER, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic       HS_EN = (MEM_HANDSHAKE != 0);
    localparam logic       TRAP_EN = (TRAP_ON_ILLEGAL != 0);
    localparam logic [3:0] LAT = MEM_LATENCY[3:0];

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       illegal_q, illegal_d;
    logic       mem_done, in_mem;
    logic       dec_ill;
    state_t     dec_next;
    logic [3:0] alu_fn;
    logic       br_take;

    assign in_mem = (state_q == S_FETCH) || (state_q == S_MEMREAD)
                 || (state_q == S_MEMWRITE);
    assign mem_done = HS_EN ? mem_ready : (cnt_q == LAT);
    assign cnt_d = (in_mem && !mem_done) ? cnt_q + 4'd1 : 4'd0;
    assign illegal_d = ((state_q == S_DECODE) && dec_ill)
                    || (TRAP_EN && illegal_q);
    assign illegal = illegal_q;
    assign state = state_q;

    // Opcode decode: successor of DECODE and illegal detection.
    always_comb begin
        dec_ill = 1'b0;
        dec_next = S_TRAP;
        unique case (opcode)
            OP_LOAD, OP_STORE: dec_next = S_MEMADR;
            OP_R:              dec_next = S_EXECR;
            OP_I:              dec_next = S_EXECI;
            OP_BR: begin
                dec_next = S_BRANCH;
                dec_ill = (funct3[2:1] == 2'b01);
            end
            OP_JAL:            dec_next = S_JAL;
            OP_JALR:           dec_next = S_JALR;
            OP_LUI, OP_AUIPC:  dec_next = S_UPPER;
            default:           dec_ill = 1'b1;
        endcase
        if (dec_ill) dec_next = TRAP_EN ? S_TRAP : S_FETCH;
    end

    // ALU function for R/I ops; SUB only exists in R-type.
    always_comb begin
        alu_fn = 4'b0000;
        unique case (funct3)
            3'b000: alu_fn = (func7_bit5 && state_q == S_EXECR)
                           ? 4'b0001 : 4'b0000;
            3'b001: alu_fn = 4'b0111;
            3'b010: alu_fn = 4'b0101;
            3'b011: alu_fn = 4'b0110;
            3'b100: alu_fn = 4'b0100;
            3'b101: alu_fn = func7_bit5 ? 4'b1001 : 4'b1000;
            3'b110: alu_fn = 4'b0011;
            3'b111: alu_fn = 4'b0010;
            default: alu_fn = 4'b0000;
        endcase
    end

    // Branch condition from the ALU flags.
    always_comb begin
        br_take = 1'b0;
        unique case (funct3)
            3'b000: br_take = zero;
            3'b001: br_take = !zero;
            3'b100: br_take = lt;
            3'b101: br_take = !lt;
            3'b110: br_take = ltu;
            3'b111: br_take = !ltu;
            default: br_take = 1'b0;
        endcase
    end

    // Next state and datapath controls per state.
    always_comb begin
        state_d = state_q;
        pcwrite = 1'b0;
        irwrite = 1'b0;
        regwrite = 1'b0;
        memwrite = 1'b0;
        memread = 1'b0;
        adrsource = 1'b0;
        imm_source = 3'b000;
        alu_source_a = 2'b00;
        alu_source_b = 2'b00;
        alu_control = 4'b0000;
        resultsource = 2'b00;
        unique case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                memread = 1'b1;
                alu_source_b = 2'b10;
                if (mem_done) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_source_a = 2'b01;
                alu_source_b = 2'b01;
                imm_source = (opcode == OP_JAL) ? 3'b100 : 3'b010;
                state_d = dec_next;
            end
            S_MEMADR: begin
                alu_source_a = 2'b10;
                alu_source_b = 2'b01;
                if (opcode == OP_STORE) begin
                    imm_source = 3'b001;
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                memread = 1'b1;
                adrsource = 1'b1;
                if (mem_done) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                resultsource = 2'b01;
                regwrite = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWRITE: begin
                memwrite = 1'b1;
                adrsource = 1'b1;
                if (mem_done) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_source_a = 2'b10;
                alu_control = alu_fn;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                alu_source_a = 2'b10;
                alu_source_b = 2'b01;
                alu_control = alu_fn;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                resultsource = 2'b10;
                regwrite = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_source_a = 2'b10;
                alu_control = 4'b0001;
                resultsource = 2'b10;
                pcwrite = br_take;
                state_d = S_FETCH;
            end
            S_JAL, S_JALR_PC: begin
                pcwrite = 1'b1;
                resultsource = 2'b10;
                alu_source_a = 2'b01;
                alu_source_b = 2'b10;
                state_d = S_ALUWB;
            end
            S_JALR: begin
                alu_source_a = 2'b10;
                alu_source_b = 2'b01;
                state_d = S_JALR_PC;
            end
            S_UPPER: begin
                imm_source = 3'b011;
                alu_source_b = 2'b01;
                alu_source_a = (opcode == OP_LUI) ? 2'b11 : 2'b01;
                state_d = S_ALUWB;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_RESET;
        endcase
    end

    // State, wait counter and illegal flag registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_RESET;
            cnt_q <= 4'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_control_unit_mc.sv
// Scoreboard bench for control_unit_mc across three
// parameter sets (latency, handshake, trap modes).
module tb_control_unit_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, zf, ltf, ltuf, mrdy;

    logic [2:0] pcw, irw, rgw, mw, mr, adr, ill;
    logic [3:0] st[3];
    logic [3:0] aluc[3];
    logic [1:0] rs[3];
    logic [2:0] imm[3];
    logic [1:0] srca[3];
    logic [1:0] srcb[3];

    control_unit_mc #(.MEM_HANDSHAKE(0), .MEM_LATENCY(0),
                      .TRAP_ON_ILLEGAL(1)) u0 (
        .clk(clk), .reset(rst[0]), .opcode(op), .funct3(f3),
        .func7_bit5(f7), .zero(zf), .lt(ltf), .ltu(ltuf),
        .mem_ready(mrdy), .pcwrite(pcw[0]), .irwrite(irw[0]),
        .regwrite(rgw[0]), .memwrite(mw[0]), .memread(mr[0]),
        .adrsource(adr[0]), .imm_source(imm[0]),
        .alu_source_a(srca[0]), .alu_source_b(srcb[0]),
        .alu_control(aluc[0]), .resultsource(rs[0]),
        .illegal(ill[0]), .state(st[0]));

    control_unit_mc #(.MEM_HANDSHAKE(0), .MEM_LATENCY(2),
                      .TRAP_ON_ILLEGAL(1)) u1 (
        .clk(clk), .reset(rst[1]), .opcode(op), .funct3(f3),
        .func7_bit5(f7), .zero(zf), .lt(ltf), .ltu(ltuf),
        .mem_ready(mrdy), .pcwrite(pcw[1]), .irwrite(irw[1]),
        .regwrite(rgw[1]), .memwrite(mw[1]), .memread(mr[1]),
        .adrsource(adr[1]), .imm_source(imm[1]),
        .alu_source_a(srca[1]), .alu_source_b(srcb[1]),
        .alu_control(aluc[1]), .resultsource(rs[1]),
        .illegal(ill[1]), .state(st[1]));

    control_unit_mc #(.MEM_HANDSHAKE(1), .MEM_LATENCY(0),
                      .TRAP_ON_ILLEGAL(0)) u2 (
        .clk(clk), .reset(rst[2]), .opcode(op), .funct3(f3),
        .func7_bit5(f7), .zero(zf), .lt(ltf), .ltu(ltuf),
        .mem_ready(mrdy), .pcwrite(pcw[2]), .irwrite(irw[2]),
        .regwrite(rgw[2]), .memwrite(mw[2]), .memread(mr[2]),
        .adrsource(adr[2]), .imm_source(imm[2]),
        .alu_source_a(srca[2]), .alu_source_b(srcb[2]),
        .alu_control(aluc[2]), .resultsource(rs[2]),
        .illegal(ill[2]), .state(st[2]));

    // strobe bits: {pcwrite,irwrite,regwrite,memwrite,memread,adrsource,illegal}
    localparam logic [6:0] P = 7'b1000000;
    localparam logic [6:0] I = 7'b0100000;
    localparam logic [6:0] R = 7'b0010000;
    localparam logic [6:0] W = 7'b0001000;
    localparam logic [6:0] M = 7'b0000100;
    localparam logic [6:0] A = 7'b0000010;
    localparam logic [6:0] L = 7'b0000001;
    localparam logic [6:0] N = 7'b0000000;

    typedef struct {
        int         id;
        string      tag;
        logic [3:0] st;
        logic [6:0] sb;
        logic [3:0] alu;
        logic [1:0] rs;
        logic       cm;
        logic [6:0] mux;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t        e;
    logic [16:0] act, req;
    logic [6:0]  mact;

    // Monitor: every queued expectation is checked at the falling edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            act = {st[e.id], pcw[e.id], irw[e.id], rgw[e.id], mw[e.id],
                   mr[e.id], adr[e.id], ill[e.id], aluc[e.id], rs[e.id]};
            req = {e.st, e.sb, e.alu, e.rs};
            n_cmp++;
            if (act !== req) begin
                n_bad++;
                $display("FAIL %s dut%0d: got st=%0d strb=%b alu=%b rs=%b, want st=%0d strb=%b alu=%b rs=%b",
                         e.tag, e.id, act[16:13], act[12:6], act[5:2],
                         act[1:0], e.st, e.sb, e.alu, e.rs);
            end
            if (e.cm) begin
                mact = {imm[e.id], srca[e.id], srcb[e.id]};
                n_cmp++;
                if (mact !== e.mux) begin
                    n_bad++;
                    $display("FAIL %s_mux dut%0d: got imm/a/b=%b want %b",
                             e.tag, e.id, mact, e.mux);
                end
            end
        end
    end

    task automatic chk(input int id, input string tag,
                       input logic [3:0] s, input logic [6:0] sb,
                       input logic [3:0] alu = 4'b0000,
                       input logic [1:0] r = 2'b00,
                       input logic cm = 1'b0,
                       input logic [6:0] mux = 7'b0);
        exp_t x;
        x.id = id; x.tag = tag; x.st = s; x.sb = sb;
        x.alu = alu; x.rs = r; x.cm = cm; x.mux = mux;
        q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ins(input logic [6:0] o, input logic [2:0] f,
                           input logic f7b);
        op = o; f3 = f; f7 = f7b;
    endtask

    // Single-cycle fetch that completes, with its mux settings.
    task automatic fetch_done(input int id, input logic [6:0] x = N);
        chk(id, "fetch", 4'd1, P | I | M | x, 4'b0000, 2'b00,
            1'b1, 7'b000_00_10);
        tick();
    endtask

    task automatic decode(input int id, input logic [2:0] im,
                          input logic [6:0] x = N);
        chk(id, "decode", 4'd2, x, 4'b0000, 2'b00, 1'b1, {im, 4'b0101});
        tick();
    endtask

    task automatic aluwb(input int id);
        chk(id, "aluwb", 4'd9, R, 4'b0000, 2'b10);
        tick();
    endtask

    initial begin
        rst = 3'b000;
        set_ins(7'b0, 3'b0, 1'b0);
        zf = 0; ltf = 0; ltuf = 0; mrdy = 0;
        tick();
        for (int i = 0; i < 3; i++)
            chk(i, "reset", 4'd0, N, 4'b0000, 2'b00, 1'b1, 7'b0);
        tick();

        // ---------- dut0: zero latency, trapping ----------
        rst[0] = 1'b1;
        chk(0, "rst_rel", 4'd0, N);
        tick();
        set_ins(7'b0010011, 3'b000, 1'b0);
        fetch_done(0);
        decode(0, 3'b010);
        chk(0, "addi", 4'd8, N, 4'b0000, 2'b00, 1'b1, 7'b000_10_01);
        tick();
        aluwb(0);
        set_ins(7'b0110011, 3'b000, 1'b1);
        fetch_done(0);
        decode(0, 3'b010);
        chk(0, "sub", 4'd7, N, 4'b0001, 2'b00, 1'b1, 7'b000_10_00);
        tick();
        aluwb(0);
        set_ins(7'b0010011, 3'b000, 1'b1);
        fetch_done(0);
        decode(0, 3'b010);
        chk(0, "addi_f7", 4'd8, N, 4'b0000);
        tick();
        aluwb(0);
        set_ins(7'b0010011, 3'b101, 1'b1);
        fetch_done(0);
        decode(0, 3'b010);
        chk(0, "srai", 4'd8, N, 4'b1001);
        tick();
        aluwb(0);
        set_ins(7'b0110011, 3'b011, 1'b0);
        fetch_done(0);
        decode(0, 3'b010);
        chk(0, "sltu", 4'd7, N, 4'b0110);
        tick();
        aluwb(0);
        set_ins(7'b0110011, 3'b111, 1'b0);
        fetch_done(0);
        decode(0, 3'b010);
        chk(0, "and", 4'd7, N, 4'b0010);
        tick();
        aluwb(0);
        // branches
        set_ins(7'b1100011, 3'b000, 1'b0);
        zf = 1;
        fetch_done(0);
        decode(0, 3'b010);
        chk(0, "beq_t", 4'd10, P, 4'b0001, 2'b10, 1'b1, 7'b000_10_00);
        tick();
        set_ins(7'b1100011, 3'b110, 1'b0);
        zf = 0; ltuf = 0;
        fetch_done(0);
        decode(0, 3'b010);
        chk(0, "bltu_nt", 4'd10, N, 4'b0001, 2'b10);
        tick();
        set_ins(7'b1100011, 3'b001, 1'b0);
        zf = 1;
        fetch_done(0);
        decode(0, 3'b010);
        chk(0, "bne_nt", 4'd10, N, 4'b0001, 2'b10);
        tick();
        set_ins(7'b1100011, 3'b101, 1'b0);
        zf = 0; ltf = 0;
        fetch_done(0);
        decode(0, 3'b010);
        chk(0, "bge_t", 4'd10, P, 4'b0001, 2'b10);
        tick();
        // jumps and upper
        set_ins(7'b1101111, 3'b000, 1'b0);
        fetch_done(0);
        decode(0, 3'b100);
        chk(0, "jal", 4'd11, P, 4'b0000, 2'b10, 1'b1, 7'b000_01_10);
        tick();
        aluwb(0);
        set_ins(7'b1100111, 3'b000, 1'b0);
        fetch_done(0);
        decode(0, 3'b010);
        chk(0, "jalr", 4'd12, N, 4'b0000, 2'b00, 1'b1, 7'b000_10_01);
        tick();
        chk(0, "jalr_pc", 4'd13, P, 4'b0000, 2'b10, 1'b1, 7'b000_01_10);
        tick();
        aluwb(0);
        set_ins(7'b0110111, 3'b000, 1'b0);
        fetch_done(0);
        decode(0, 3'b010);
        chk(0, "lui", 4'd14, N, 4'b0000, 2'b00, 1'b1, 7'b011_11_01);
        tick();
        aluwb(0);
        set_ins(7'b0010111, 3'b000, 1'b0);
        fetch_done(0);
        decode(0, 3'b010);
        chk(0, "auipc", 4'd14, N, 4'b0000, 2'b00, 1'b1, 7'b011_01_01);
        tick();
        aluwb(0);
        // illegal opcode traps
        set_ins(7'b1111111, 3'b000, 1'b0);
        fetch_done(0);
        decode(0, 3'b010);
        chk(0, "trap0", 4'd15, L);
        tick();
        mrdy = 1;
        chk(0, "trap1", 4'd15, L);
        tick();
        mrdy = 0;
        rst[0] = 1'b0;
        chk(0, "trap2", 4'd15, L);
        tick();
        chk(0, "trap_rst", 4'd0, N);
        tick();

        // ---------- dut1: latency 2 ----------
        rst[1] = 1'b1;
        chk(1, "rst_rel", 4'd0, N);
        tick();
        set_ins(7'b0000011, 3'b010, 1'b0);
        chk(1, "fetch_w0", 4'd1, M);
        tick();
        chk(1, "fetch_w1", 4'd1, M);
        tick();
        fetch_done(1);
        decode(1, 3'b010);
        chk(1, "lw_adr", 4'd3, N, 4'b0000, 2'b00, 1'b1, 7'b000_10_01);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk(1, "lw_rd", 4'd4, M | A);
            tick();
        end
        chk(1, "lw_wb", 4'd5, R, 4'b0000, 2'b01);
        tick();
        set_ins(7'b0100011, 3'b010, 1'b0);
        chk(1, "fetch_w0", 4'd1, M);
        tick();
        chk(1, "fetch_w1", 4'd1, M);
        tick();
        fetch_done(1);
        decode(1, 3'b010);
        chk(1, "sw_adr", 4'd3, N, 4'b0000, 2'b00, 1'b1, 7'b001_10_01);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk(1, "sw_wr", 4'd6, W | A);
            tick();
        end
        // reset in the middle of a read wait
        set_ins(7'b0000011, 3'b010, 1'b0);
        chk(1, "fetch_w0", 4'd1, M);
        tick();
        chk(1, "fetch_w1", 4'd1, M);
        tick();
        fetch_done(1);
        decode(1, 3'b010);
        chk(1, "lw_adr", 4'd3, N);
        tick();
        chk(1, "lw_rd0", 4'd4, M | A);
        tick();
        rst[1] = 1'b0;
        chk(1, "lw_rd1", 4'd4, M | A);
        tick();
        rst[1] = 1'b1;
        chk(1, "mid_rst", 4'd0, N);
        tick();
        chk(1, "refetch0", 4'd1, M);
        tick();
        chk(1, "refetch1", 4'd1, M);
        tick();
        fetch_done(1);
        decode(1, 3'b010);
        rst[1] = 1'b0;

        // ---------- dut2: handshake, non-trapping ----------
        rst[2] = 1'b1;
        chk(2, "rst_rel", 4'd0, N);
        tick();
        set_ins(7'b0100011, 3'b010, 1'b0);
        mrdy = 0;
        chk(2, "fetch_hs", 4'd1, M);
        tick();
        mrdy = 1;
        fetch_done(2);
        decode(2, 3'b010);
        mrdy = 0;
        chk(2, "sw_adr", 4'd3, N, 4'b0000, 2'b00, 1'b1, 7'b001_10_01);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk(2, "sw_hold", 4'd6, W | A);
            tick();
        end
        mrdy = 1;
        chk(2, "sw_done", 4'd6, W | A);
        tick();
        set_ins(7'b1100011, 3'b011, 1'b0);
        fetch_done(2);
        decode(2, 3'b010);
        set_ins(7'b0010011, 3'b000, 1'b0);
        fetch_done(2, L);
        decode(2, 3'b010);
        chk(2, "addi_hs", 4'd8, N);
        tick();
        aluwb(2);

        // drain the scoreboard, bounded
        for (int k = 0; k < 4 && q.size() > 0; k++) tick();
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
